// File: rtl/i2c_pkg.sv
// Shared I2C definitions: master FSM states, quarter-phase encoding and bus ACK levels.
package i2c_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StAddr,
        StAddrAck,
        StWrite,
        StRead,
        StDataAck,
        StStop
    } i2c_state_e;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic AckLvl  = 1'b0;
    localparam logic NackLvl = 1'b1;

endpackage

// File: rtl/i2c_clk_gen.sv
// Quarter-period tick generator for the I2C master; i_hold restarts the current quarter.
module i2c_clk_gen
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_en,
    input  logic       i_hold,
    output logic       o_qtick,
    output logic [1:0] o_phase
);

    localparam int unsigned CntW = $clog2(CLK_DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] r_cnt;
    logic [1:0]      r_phase;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_phase <= Q0;
        end else if (!i_en) begin
            r_cnt   <= '0;
            r_phase <= Q0;
        end else if (i_hold) begin
            r_cnt   <= '0;
        end else if (r_cnt == CntMax) begin
            r_cnt   <= '0;
            r_phase <= r_phase + 2'd1;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign o_qtick = i_en && !i_hold && (r_cnt == CntMax);
    assign o_phase = r_phase;

endmodule

// File: rtl/i2c_master.sv
// Single-byte open-drain I2C master: START, address+R/W, one data byte, STOP.
// Define I2C_CLK_STRETCH_EN to let a slave stretch SCL during q2 of any bit slot.
module i2c_master
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] slave_addr,
    input  logic       rw,
    input  logic [7:0] data_in,
    input  logic       ack_master,
    output logic [7:0] data_out,
    output logic       busy,
    output logic       done,
    output logic       ack_error,
    inout  wire        scl,
    inout  wire        sda
);

    i2c_state_e r_state, w_state_nxt;
    logic [7:0] r_addr_byte, r_wdata, r_shift, r_data_out;
    logic [2:0] r_bit;
    logic       r_ack_master, r_busy, r_done, r_ack_error;
    logic [1:0] r_sda_s;
    logic       w_en, w_hold, w_qtick, w_sample, w_slot_end, w_scl_low, w_sda_low;
    logic [1:0] w_phase;

    assign w_en       = (r_state != StIdle);
    assign w_sample   = w_qtick && (w_phase == Q2);
    assign w_slot_end = w_qtick && (w_phase == Q3);

`ifdef I2C_CLK_STRETCH_EN
    logic [1:0] r_scl_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_scl_s <= 2'b11;
        else        r_scl_s <= {r_scl_s[0], scl};
    end

    assign w_hold = w_en && (w_phase == Q2) && !r_scl_s[1];
`else
    assign w_hold = 1'b0;
`endif

    i2c_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_en),
        .i_hold  (w_hold),
        .o_qtick (w_qtick),
        .o_phase (w_phase)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= StIdle;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_scl_low   = 1'b0;
        w_sda_low   = 1'b0;
        unique case (r_state)
            StIdle: if (start) w_state_nxt = StStart;
            StStart: begin
                // SDA falls mid-slot with SCL high; SCL drops for the last quarter
                w_scl_low = (w_phase == Q3);
                w_sda_low = w_phase[1];
                if (w_slot_end) w_state_nxt = StAddr;
            end
            StAddr: begin
                w_scl_low = !w_phase[1];
                w_sda_low = !r_addr_byte[3'd7 - r_bit];
                if (w_slot_end && r_bit == 3'd7) w_state_nxt = StAddrAck;
            end
            StAddrAck: begin
                w_scl_low = !w_phase[1];
                if (w_slot_end) begin
                    if (r_ack_error)         w_state_nxt = StStop;
                    else if (r_addr_byte[0]) w_state_nxt = StRead;
                    else                     w_state_nxt = StWrite;
                end
            end
            StWrite: begin
                w_scl_low = !w_phase[1];
                w_sda_low = !r_wdata[3'd7 - r_bit];
                if (w_slot_end && r_bit == 3'd7) w_state_nxt = StDataAck;
            end
            StRead: begin
                w_scl_low = !w_phase[1];
                if (w_slot_end && r_bit == 3'd7) w_state_nxt = StDataAck;
            end
            StDataAck: begin
                w_scl_low = !w_phase[1];
                w_sda_low = r_addr_byte[0] && (r_ack_master == AckLvl);
                if (w_slot_end) w_state_nxt = StStop;
            end
            StStop: begin
                w_scl_low = !w_phase[1];
                w_sda_low = (w_phase != Q3);
                if (w_slot_end) w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr_byte  <= '0;
            r_wdata      <= '0;
            r_ack_master <= 1'b0;
            r_shift      <= '0;
            r_data_out   <= '0;
            r_bit        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_ack_error  <= 1'b0;
            r_sda_s      <= 2'b11;
        end else begin
            r_sda_s <= {r_sda_s[0], sda};
            r_done  <= 1'b0;
            if (r_state == StIdle && start) begin
                r_addr_byte  <= {slave_addr, rw};
                r_wdata      <= data_in;
                r_ack_master <= ack_master;
                r_bit        <= '0;
                r_busy       <= 1'b1;
                r_ack_error  <= 1'b0;
            end
            if (w_sample) begin
                if (r_state == StAddrAck && r_sda_s[1] == NackLvl) r_ack_error <= 1'b1;
                if (r_state == StDataAck && !r_addr_byte[0] && r_sda_s[1] == NackLvl) begin
                    r_ack_error <= 1'b1;
                end
                if (r_state == StRead) r_shift <= {r_shift[6:0], r_sda_s[1]};
            end
            if (w_slot_end) begin
                if (r_state == StAddr || r_state == StWrite || r_state == StRead) begin
                    r_bit <= r_bit + 3'd1;
                end
                if (r_state == StRead && r_bit == 3'd7) r_data_out <= r_shift;
                if (r_state == StStop) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign scl       = w_scl_low ? 1'b0 : 1'bz;
    assign sda       = w_sda_low ? 1'b0 : 1'bz;
    assign data_out  = r_data_out;
    assign busy      = r_busy;
    assign done      = r_done;
    assign ack_error = r_ack_error;

endmodule

// File: tb/tb_i2c_master.sv
// Scoreboard bench for i2c_master with a behavioural open-drain slave on the bus.
module tb_i2c_master;

    localparam int unsigned CD = 4;
`ifdef I2C_CLK_STRETCH_EN
    localparam bit StretchBuild = 1'b1;
`else
    localparam bit StretchBuild = 1'b0;
`endif
    localparam int SIdle = 0, SAddr = 1, SWdata = 2, SRdata = 3;

    logic       clk = 1'b0, reset = 1'b0, start = 1'b0, rw = 1'b0, ack_master = 1'b0;
    logic [6:0] slave_addr = '0;
    logic [7:0] data_in = '0;
    wire  [7:0] data_out;
    wire        busy, done, ack_error;
    wire        scl, sda;

    pullup (scl);
    pullup (sda);

    logic s_scl_hold = 1'b0, s_sda_low = 1'b0;
    assign scl = s_scl_hold ? 1'b0 : 1'bz;
    assign sda = s_sda_low ? 1'b0 : 1'bz;

    i2c_master #(
        .CLK_DIV (CD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .slave_addr (slave_addr),
        .rw         (rw),
        .data_in    (data_in),
        .ack_master (ack_master),
        .data_out   (data_out),
        .busy       (busy),
        .done       (done),
        .ack_error  (ack_error),
        .scl        (scl),
        .sda        (sda)
    );

    always #5 clk = ~clk;

    // Behavioural slave, sampling the bus on the falling system clock edge.
    int         s_ph = SIdle, s_cnt = 0, s_wcnt = 0, s_stretch_cnt = 0;
    logic       s_pscl = 1'b1, s_psda = 1'b1, s_mack = 1'b0;
    logic [7:0] s_sh = '0, s_addr_cap = '0, s_wdata_cap = '0;
    logic [7:0] s_rdata = 8'h3C;
    bit         s_ack_en = 1'b1, s_stretch = 1'b0;

    always @(negedge clk) begin
        s_pscl <= scl;
        s_psda <= sda;
        if (s_stretch_cnt > 0) begin
            s_stretch_cnt <= s_stretch_cnt - 1;
            if (s_stretch_cnt == 1) s_scl_hold <= 1'b0;
        end
        if (scl && s_pscl && s_psda && !sda) begin
            s_ph <= SAddr; s_cnt <= 0; s_sh <= '0; s_wcnt <= 0;
            s_sda_low <= 1'b0; s_addr_cap <= '0; s_mack <= 1'b0;
        end else if (scl && s_pscl && !s_psda && sda) begin
            s_ph <= SIdle; s_sda_low <= 1'b0;
        end else if (scl && !s_pscl) begin
            if ((s_ph == SAddr || s_ph == SWdata) && s_cnt < 8) begin
                s_sh  <= {s_sh[6:0], sda};
                s_cnt <= s_cnt + 1;
            end else if (s_ph == SRdata && s_cnt == 9) begin
                s_mack <= sda;
            end
        end else if (!scl && s_pscl) begin
            case (s_ph)
                SAddr: begin
                    if (s_cnt == 8) begin
                        s_addr_cap <= s_sh;
                        if (s_ack_en) begin
                            s_sda_low <= 1'b1;
                            s_cnt     <= 9;
                            if (s_stretch) begin
                                s_scl_hold    <= 1'b1;
                                s_stretch_cnt <= 100;
                            end
                        end else begin
                            s_ph <= SIdle;
                        end
                    end else if (s_cnt == 9) begin
                        if (s_addr_cap[0]) begin
                            s_ph <= SRdata; s_sda_low <= !s_rdata[7]; s_cnt <= 1;
                        end else begin
                            s_ph <= SWdata; s_sda_low <= 1'b0; s_cnt <= 0; s_sh <= '0;
                        end
                    end
                end
                SWdata: begin
                    if (s_cnt == 8) begin
                        s_wdata_cap <= s_sh; s_wcnt <= s_wcnt + 1;
                        s_sda_low <= 1'b1; s_cnt <= 9;
                    end else if (s_cnt == 9) begin
                        s_sda_low <= 1'b0; s_ph <= SIdle;
                    end
                end
                SRdata: begin
                    if (s_cnt < 8) begin
                        s_sda_low <= !s_rdata[7-s_cnt]; s_cnt <= s_cnt + 1;
                    end else if (s_cnt == 8) begin
                        s_sda_low <= 1'b0; s_cnt <= 9;
                    end else begin
                        s_ph <= SIdle;
                    end
                end
                default: ;
            endcase
        end
    end

    typedef struct {
        logic [7:0] dout;
        logic       err;
        bit         chk_err;
        int         cyc;
        bit         cyc_min;
        bit         chk_bytes;
        logic [7:0] addr;
        int         wcnt;
        logic [7:0] wdata;
        bit         chk_mack;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0, n_err = 0, done_cnt = 0, m_cyc = 0;
    logic m_bprev = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_ge(input string nm, input int act, input int lo);
        n_chk++;
        if (act < lo) begin
            n_err++;
            $display("FAIL %s: got %0d, expected at least %0d", nm, act, lo);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] dout, input logic err, input int cyc,
                                input logic [7:0] addr, input int wcnt, input logic [7:0] wdata,
                                input bit chk_mack);
        exp_t e;
        e.dout = dout; e.err = err; e.chk_err = 1'b1; e.cyc = cyc; e.cyc_min = StretchBuild;
        e.chk_bytes = 1'b1; e.addr = addr; e.wcnt = wcnt; e.wdata = wdata;
        e.chk_mack = chk_mack;
        return e;
    endfunction

    // Monitor: measures busy-to-done latency and checks each done against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy && !m_bprev) m_cyc = 0;
            else                  m_cyc++;
            m_bprev = busy;
            if (done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL unexpected_done: got a done pulse, expected none");
                end else begin
                    e = sb.pop_front();
                    chk("data_out", data_out, e.dout);
                    if (e.chk_err) chk("ack_error", ack_error, e.err);
                    if (e.cyc_min) chk_ge("latency", m_cyc, e.cyc);
                    else           chk("latency", m_cyc, e.cyc);
                    if (e.chk_bytes) begin
                        chk("addr_byte", s_addr_cap, e.addr);
                        chk("wr_count", s_wcnt, e.wcnt);
                        if (e.wcnt > 0) chk("wr_byte", s_wdata_cap, e.wdata);
                    end
                    if (e.chk_mack) chk("read_ack_released", s_mack, 1);
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input int base, input string nm);
        int n = 0;
        while (done_cnt == base && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == base) begin
            n_chk++; n_err++;
            $display("FAIL %s_timeout: got no done, expected done within 3000 cycles", nm);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic run(input logic [6:0] a, input logic r, input logic [7:0] d,
                       input logic am, input exp_t e, input string nm);
        int base = done_cnt;
        slave_addr = a; rw = r; data_in = d; ack_master = am;
        sb.push_back(e);
        pulse_start();
        wait_done(base, nm);
    endtask

    initial begin
        int   base, n;
        exp_t e;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ack_error", ack_error, 0);
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_scl", scl, 1);
        chk("rst_sda", sda, 1);
        @(negedge clk) reset = 1'b1;
        repeat (3) @(negedge clk);

        run(7'h50, 1'b0, 8'hA5, 1'b0, mk(8'h00, 1'b0, 80*CD, 8'hA0, 1, 8'hA5, 1'b0), "write");
        run(7'h50, 1'b1, 8'h00, 1'b1, mk(8'h3C, 1'b0, 80*CD, 8'hA1, 0, 8'h00, 1'b1), "read");

        s_ack_en = 1'b0;
        run(7'h50, 1'b0, 8'hA5, 1'b0, mk(8'h3C, 1'b1, 44*CD, 8'hA0, 0, 8'h00, 1'b0), "nack");
        s_ack_en = 1'b1;

        // Second start while busy must be ignored and must not disturb latched values.
        base = done_cnt;
        slave_addr = 7'h12; rw = 1'b0; data_in = 8'h5A; ack_master = 1'b0;
        sb.push_back(mk(8'h3C, 1'b0, 80*CD, 8'h24, 1, 8'h5A, 1'b0));
        pulse_start();
        repeat (50) @(negedge clk);
        slave_addr = 7'h7F; rw = 1'b1; data_in = 8'h00; ack_master = 1'b1;
        pulse_start();
        wait_done(base, "busy_restart");
        repeat (400) @(negedge clk);
        chk("single_done", done_cnt - base, 1);

        // Reset during address bit 3.
        slave_addr = 7'h50; rw = 1'b0; data_in = 8'hA5;
        pulse_start();
        n = 0;
        while (!(s_ph == SAddr && s_cnt == 3) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("reach_addr_bit3", (s_ph == SAddr && s_cnt == 3) ? 1 : 0, 1);
        repeat (6) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        sb.delete();
        chk("midrst_scl", scl, 1);
        chk("midrst_sda", sda, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_data_out", data_out, 8'h00);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        run(7'h2B, 1'b0, 8'hC3, 1'b0, mk(8'h00, 1'b0, 80*CD, 8'h56, 1, 8'hC3, 1'b0), "post_rst");

        // Slave holds SCL low in the address ACK slot.
        s_stretch = 1'b1;
        e = mk(8'h00, 1'b0, 80*CD, 8'hA0, 1, 8'hA5, 1'b0);
        if (StretchBuild) begin
            e.cyc = 80*CD + 100;
        end else begin
            e.chk_err = 1'b0;
            e.chk_bytes = 1'b0;
        end
        run(7'h50, 1'b0, 8'hA5, 1'b0, e, "stretch");
        s_stretch = 1'b0;
        repeat (20) @(negedge clk);

        if (sb.size() != 0) begin
            n_chk++; n_err++;
            $display("FAIL pending_expect: got %0d unmatched entries, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/i2c_master.md
# i2c_master

Single-byte I2C master controller: on a `start` request it generates START, sends a 7-bit address plus R/W, and writes or reads one data byte. It then generates STOP and pulses `done`. It is the initiator end of the bus driven by the team's `i2c_slave`, and sits between a CPU-side register interface and the open-drain `scl`/`sda` pads. Both lines are driven open-drain: the block only ever pulls a line low or releases it (Z).

## Interface
Parameters:
- `CLK_DIV`, default 125: system clocks per SCL quarter-period. Legal range is 4 or more; SCL frequency = f_clk / (4·CLK_DIV).

Ports:
- `clk` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: request a transaction. Sampled only in IDLE.
- `slave_addr` input 7: target address.
- `rw` input 1: 0 = write, 1 = read.
- `data_in` input 8: byte to write.
- `ack_master` input 1: level the master drives on the read-ACK bit. 0 = ACK, 1 = NACK.
- `data_out` output 8: byte read.
- `busy` output 1: high from acceptance of `start` until `done`.
- `done` output 1: one-cycle pulse at the end of a transaction.
- `ack_error` output 1: slave NACKed the address or the write byte. Valid with `done`; held until the next acceptance.
- `scl` inout 1: I2C clock, open-drain.
- `sda` inout 1: I2C data, open-drain.

## Operation
- Reset values: `scl`/`sda` released (Z), `busy` 0, `done` 0, `ack_error` 0, `data_out` 0x00, state IDLE.
- Acceptance:
  - In IDLE, `start`=1 latches `slave_addr`, `rw`, `data_in` and `ack_master`.
  - `busy` rises on the next cycle and `ack_error` clears.
  - `start` is ignored while `busy`=1.
- Each bit slot has four quarters (q0..q3) of `CLK_DIV` clocks each:
  - q0: SCL low; SDA updated at the start of q0.
  - q1: SCL low.
  - q2: SCL released; SDA sampled at the end of q2.
  - q3: SCL high.
- States: IDLE → START → ADDR (8 bits, MSB first, `{slave_addr, rw}`) → ADDR_ACK → WRITE or READ (8 bits) → DATA_ACK → STOP → IDLE.
- START: SDA falls while SCL is high, in mid-slot. The slot then ends with SCL low.
- ADDR_ACK / write DATA_ACK:
  - SDA is released and sampled in q2.
  - A sampled 1 sets `ack_error` and jumps to STOP, skipping any remaining data phase.
- READ:
  - SDA is released and the bit is sampled in q2 into a shift register.
  - `data_out` updates at the end of the 8th bit.
- Read DATA_ACK: SDA is driven low if the latched `ack_master`=0, otherwise released.
- STOP: SDA is held low in q0–q1, SCL is released in q2, and SDA is released in q3.
  - `done` pulses on the cycle STOP completes, together with `busy` falling.
- `scl`/`sda` inputs pass through a 2-flop synchronizer before use. Sampling occurs no earlier than 2 clocks after a release.
- Reset mid-transaction: lines are released asynchronously and all state returns to reset values. No STOP is generated.
- Arbitration loss and multi-master are not supported. Repeated START is not supported.

## Timing
- Full transaction (START + 9 address slots + 9 data slots + STOP) = 20 slots = 80·CLK_DIV clocks from `busy` rising to `done`, with no stretching.
- NACK on address: 11 slots = 44·CLK_DIV clocks.
- `start`→`busy`: 1 clock. `done` width: exactly 1 clock.
- A new `start` can be accepted on the cycle after `done`.

## Configuration
- `I2C_CLK_STRETCH_EN` defined:
  - In q2, after SCL is released, the quarter counter holds while the synchronized `scl` reads 0.
  - The q2 countdown restarts once `scl` reads 1, so a slave may extend any bit.
- Not defined: `scl` input is ignored and timing is strictly 4·CLK_DIV per slot.

## Structure
- Package `i2c_pkg`: state encoding, quarter-phase constants (Q0..Q3), and the ACK/NACK level constants shared with `i2c_slave`.
- Sub-module `i2c_clk_gen`:
  - Quarter-tick counter parameterized by `CLK_DIV`.
  - Outputs `qtick` and the 2-bit phase.
  - Takes a `hold` input used for stretching.

## Test plan
- Write, `CLK_DIV`=4, addr 0x50, `data_in` 0xA5, slave ACKs both → bits on SDA are 0xA0 then 0xA5; `ack_error`=0; `done` occurs 320 clocks after `busy`.
- Read, addr 0x50, slave returns 0x3C, `ack_master`=1 → `data_out`=0x3C; SDA is released on the 9th data slot; STOP follows.
- Address NACK (slave silent) → `ack_error`=1, no data slots, STOP, `done` at 176 clocks.
- `start` pulsed again while `busy` → ignored; exactly one `done`; latched values unchanged.
- `reset` asserted during ADDR bit 3 → `scl`/`sda` are Z and `busy`=0 immediately. A later `start` runs a clean transaction.
- `I2C_CLK_STRETCH_EN`, slave holds SCL low 100 clocks in ADDR_ACK → transaction is extended by ≥100 clocks and data is correct. Without the macro, the total stays at 320.
